// File: rtl/registers_bank_dumper_pkg.sv
// registers_bank_dumper_pkg: shared defaults, byte width and FSM encoding for the register dumper
package registers_bank_dumper_pkg;
  localparam int DEFAULT_REGISTERS_BANK_SIZE = 32;
  localparam int DEFAULT_REGISTERS_SIZE = 32;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CHECKSUM = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/registers_bank_dumper.sv
// registers_bank_dumper: snapshots the debug bus and streams it out bytewise over valid/ready
// Optional trailing XOR checksum byte enabled by REGISTERS_BANK_DUMPER_CHECKSUM_EN.
module registers_bank_dumper
  import registers_bank_dumper_pkg::*;
#(
  parameter int REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
  parameter int REGISTERS_SIZE = DEFAULT_REGISTERS_SIZE
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_start,
  input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
  output logic [BYTE_W-1:0]                         o_data,
  output logic                                      o_data_valid,
  input  logic                                      i_data_ready,
  output logic                                      o_busy,
  output logic                                      o_done
);
  localparam int BPR = REGISTERS_SIZE / BYTE_W;
  localparam int T = REGISTERS_BANK_SIZE * BPR;
  localparam int CW = $clog2(T + 1);
  localparam int IW = T > 1 ? $clog2(T) : 1;
  if (REGISTERS_SIZE % BYTE_W != 0) begin : g_width_check
    $error("REGISTERS_SIZE must be a multiple of 8");
  end
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [BYTE_W-1:0] snap [T];
  logic [BYTE_W-1:0] ordered [T];
  logic [BYTE_W-1:0] cur;
  logic last;
  // Reorder at capture time so stream byte k is simply snap[k].
  for (genvar k = 0; k < T; k++) begin : g_order
    assign ordered[k] = i_bus_debug[(k / BPR) * REGISTERS_SIZE + (BPR - 1 - k % BPR) * BYTE_W +: BYTE_W];
  end
  assign cur = snap[cnt[IW-1:0]];
  assign last = cnt == CW'(T - 1);
  assign o_data_valid = state == SEND || state == CHECKSUM;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
`ifdef REGISTERS_BANK_DUMPER_CHECKSUM_EN
  logic [BYTE_W-1:0] acc;
  assign o_data = state == SEND ? cur : state == CHECKSUM ? acc : '0;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) acc <= '0;
    else if (state == IDLE && i_start) acc <= '0;
    else if (state == SEND && i_data_ready) acc <= acc ^ cur;
`else
  assign o_data = state == SEND ? cur : '0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = i_start ? SEND : IDLE;
`ifdef REGISTERS_BANK_DUMPER_CHECKSUM_EN
      SEND: state_nx = i_data_ready && last ? CHECKSUM : SEND;
      CHECKSUM: state_nx = i_data_ready ? DONE : CHECKSUM;
`else
      SEND: state_nx = i_data_ready && last ? DONE : SEND;
      CHECKSUM: state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state <= IDLE;
      cnt <= '0;
      snap <= '{default: '0};
    end else begin
      state <= state_nx;
      if (state == IDLE && i_start) begin
        snap <= ordered;
        cnt <= '0;
      end else if (state == SEND && i_data_ready) begin
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_registers_bank_dumper.sv
// tb_registers_bank_dumper: random-backpressure bench against a byte-queue model of the dump
module tb_registers_bank_dumper;
  localparam int N = 32;
  localparam int W = 32;
  localparam int B = W / 8;
  logic i_clk = 0;
  logic i_reset = 0;
  logic i_start = 0;
  logic [N*W-1:0] i_bus_debug = '0;
  logic [7:0] o_data;
  logic o_data_valid;
  logic i_data_ready = 0;
  logic o_busy;
  logic o_done;
  int total = 0;
  int passed = 0;

  registers_bank_dumper #(.REGISTERS_BANK_SIZE(N), .REGISTERS_SIZE(W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_bus_debug(i_bus_debug),
    .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask

  task automatic set_pattern();
    for (int j = 0; j < N; j++) i_bus_debug[j*W +: W] = 32'h01020300 + j;
  endtask

  task automatic run_dump(input bit rnd, input bit tamper, input int abort_at);
    logic [7:0] q[$];
    logic [7:0] x;
    int idx;
    int cyc;
    bit aborted;
    idx = 0;
    cyc = 0;
    aborted = 0;
    x = 0;
    for (int j = 0; j < N; j++)
      for (int b = B - 1; b >= 0; b--) begin
        q.push_back(i_bus_debug[j*W + b*8 +: 8]);
        x ^= i_bus_debug[j*W + b*8 +: 8];
      end
`ifdef REGISTERS_BANK_DUMPER_CHECKSUM_EN
    q.push_back(x);
`endif
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    if (tamper) i_bus_debug = '1;
    while (idx < q.size() && cyc < 4000 && !aborted) begin
      chk("valid", {31'b0, o_data_valid}, 1);
      chk("data", {24'b0, o_data}, {24'b0, q[idx]});
      chk("busy", {31'b0, o_busy}, 1);
      chk("early_done", {31'b0, o_done}, 0);
      i_start = tamper && cyc == 5;
      if (idx == abort_at) begin
        i_reset = 0;
        #1;
        chk("abort_valid", {31'b0, o_data_valid}, 0);
        chk("abort_busy", {31'b0, o_busy}, 0);
        chk("abort_data", {24'b0, o_data}, 0);
        i_data_ready = 0;
        @(negedge i_clk);
        i_reset = 1;
        aborted = 1;
      end else begin
        i_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (i_data_ready) idx++;
        cyc++;
        @(negedge i_clk);
      end
    end
    i_start = 0;
    i_data_ready = 0;
    if (!aborted) begin
      chk("budget", {31'b0, cyc < 4000}, 1);
      if (!rnd) chk("latency", cyc, q.size());
      chk("done_pulse", {31'b0, o_done}, 1);
      chk("done_valid", {31'b0, o_data_valid}, 0);
      chk("done_busy", {31'b0, o_busy}, 1);
      @(negedge i_clk);
      chk("done_end", {31'b0, o_done}, 0);
      chk("idle_busy", {31'b0, o_busy}, 0);
      repeat (3) begin
        @(negedge i_clk);
        chk("stay_idle", {30'b0, o_busy, o_data_valid}, 0);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_data", {24'b0, o_data}, 0);
    chk("rst_valid", {31'b0, o_data_valid}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_done", {31'b0, o_done}, 0);
    i_reset = 1;
    @(negedge i_clk);
    set_pattern();
    run_dump(0, 0, -1);
    run_dump(1, 0, -1);
    run_dump(1, 1, -1);
    for (int j = 0; j < N; j++) i_bus_debug[j*W +: W] = $urandom;
    run_dump(1, 1, -1);
    set_pattern();
    run_dump(1, 0, 50);
    chk("post_abort_idle", {31'b0, o_busy}, 0);
    run_dump(0, 0, -1);
`ifdef REGISTERS_BANK_DUMPER_CHECKSUM_EN
    for (int j = 0; j < N; j++) i_bus_debug[j*W +: W] = 32'hA5A5A5A5;
    run_dump(1, 0, -1);
    i_bus_debug = '0;
    i_bus_debug[31:0] = 32'h000000FF;
    run_dump(0, 0, -1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
